dlx_decode_pipe: RTL and testbench
==================================

# dlx_decode_pipe

Parametrised, pipelined DLX instruction decoder sitting between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and registers the decoded control word toward execute. Adds features the previous single-register decoder lacked: XLEN-wide immediates, backpressure, pipeline flush and a one-cycle load-use interlock. Register indices follow DLX format: R-type rd = instr[15:11], I-type rd = instr[20:16].

## Interface
- XLEN, 32: datapath width; immediates and PC extended to XLEN (XLEN >= 32).
- NREG, 32: architectural registers; RW = $clog2(NREG), register fields truncated to RW bits.
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard stage contents (branch taken / exception).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decoder accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  forwarded PC.
- out_alu_op  out  4  ALU op code.
- out_rs1, out_rs2, out_rd  out  RW  source/destination indices (rd 0 = no write).
- out_imm  out  XLEN  extended immediate.
- out_use_imm  out  1  ALU operand B = out_imm.
- out_load, out_store  out  1  memory access.
- out_pc_cmd, out_pc_val  out  2  PC control (branch 2'b10/00; jump 2'b11/2'b11).
- out_illegal  out  1  undecodable opcode/funct.

## Operation
- ALU op codes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 BEQZ, 9 BNEZ, 10 SEQ, 11 SLE, 12 SLT, 13 SNE, 14 SRA, 15 JAL-link.
- R-type (op 0): funct 20/22/24/25/26/04/06/07/28/29/2a/2c -> 1/2/3/4/5/6/7/14/10/13/12/11; rd=[15:11]; use_imm=0; imm=0.
- I-type sign-extended (ADDI 08, SUBI 0a, SEQI 18, SNEI 19, SLTI 1a, SLEI 1c, LW 23, SW 2b, BEQZ 04, BNEZ 05); zero-extended (ANDI 0c, ORI 0d, XORI 0e, SLLI 14, SRLI 16, SRAI 17, LHI 0f, J 12, JAL 13). use_imm=1, rd=[20:16].
- LW: op 1, load=1. SW: op 1, store=1, rd=0. BEQZ/BNEZ: op 8/9, pc_cmd=10, rd=0. J: op 0, pc_cmd/val=11/11, rd=0. JAL: op 15, rd=NREG-1, pc_cmd/val=11/11. LHI: op 0.
- Unlisted op/funct: op 0, rd 0, load/store/pc_cmd 0, illegal per Configuration.
- Load-use interlock: ld_rd_q/ld_v_q capture out_rd when a load with nonzero rd leaves (out_valid&&out_ready); held exactly one cycle. hazard = in_valid && ld_v_q && (rs1==ld_rd_q || (R-type/SW/branch rs2 use && rs2==ld_rd_q)).

## Timing
- Latency 1: accepted at edge N -> out_valid at N+1.
- in_ready = (!out_valid || out_ready) && !hazard && !flush (combinational).
- Output register loads on in_valid&&in_ready; out_valid drops when out_ready and no new accept.
- Outputs stable while out_valid && !out_ready.
- Hazard: one bubble (out_valid=0 if drained), instruction held by fetch, accepted next cycle.
- flush: at edge, out_valid<=0, ld_v_q<=0; instruction presented that cycle not accepted. flush beats accept.
- Reset: all outputs 0, out_valid 0, ld_v_q 0; in_ready 0 while reset_n low, 1 first cycle after.

## Configuration
- DLX_DECODE_TRAP_EN defined: out_illegal=1 for unlisted opcode/funct, decoded word otherwise NOP; word still handed to execute.
- Undefined: out_illegal tied 0; unlisted encodings are silent NOPs.

## Test plan
- ADD r3,r1,r2 (0x00221820) -> next cycle out_valid=1, op 1, rs1 1, rs2 2, rd 3, use_imm 0.
- ADDI r4,r0,-1 (0x2004FFFF), XLEN=64 -> imm 0xFFFF_FFFF_FFFF_FFFF, rd 4, op 1; ANDI 0x3004FFFF -> imm 0x0000_0000_0000_FFFF.
- LW r5,0(r1) then ADD r6,r5,r5, out_ready=1 -> in_ready low one cycle, one bubble, ADD emitted one cycle later.
- out_ready low 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; release -> next word flows.
- flush with out_valid=1 and in_valid=1 -> out_valid 0 next cycle, input not accepted.
- Opcode 0x3F with TRAP_EN -> out_illegal=1, op 0, rd 0; without -> out_illegal=0.

Source files
------------

// File: rtl/dlx_decode_pipe_if.sv
// -----------------------------------------------------------------------------
// dlx_decode_pipe_if
// Bundle between fetch, the DLX decode stage and execute.
//   flush                      : discard decode stage contents
//   in_valid / in_ready        : fetch -> decoder handshake
//   in_instr, in_pc            : instruction word and its address
//   out_valid / out_ready      : decoder -> execute handshake
//   out_pc .. out_illegal      : registered decoded control word
// Modports:
//   master : environment side (drives fetch/execute controls)
//   slave  : decoder side
// -----------------------------------------------------------------------------
interface dlx_decode_pipe_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_alu_op;
  logic [RW-1:0]   out_rs1;
  logic [RW-1:0]   out_rs2;
  logic [RW-1:0]   out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_use_imm;
  logic            out_load;
  logic            out_store;
  logic [1:0]      out_pc_cmd;
  logic [1:0]      out_pc_val;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_load, out_store, out_pc_cmd, out_pc_val,
           out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_load, out_store, out_pc_cmd, out_pc_val,
           out_illegal
  );
endinterface

// File: rtl/dlx_decode_pipe.sv
// -----------------------------------------------------------------------------
// dlx_decode_pipe
// Pipelined DLX instruction decoder between fetch and execute. One instruction
// per cycle is accepted over a valid/ready handshake, decoded combinationally
// and registered toward execute (latency 1). Supports backpressure, flush and
// a one-cycle load-use interlock.
//
// Parameters:
//   XLEN : datapath width (>= 32); immediates and PC are XLEN wide
//   NREG : architectural register count; indices are $clog2(NREG) bits
// Ports:
//   clk     : clock
//   reset_n : synchronous, active-low reset
//   bus     : dlx_decode_pipe_if.slave (fetch handshake, flush, decoded word)
// Build option:
//   DLX_DECODE_TRAP_EN : when defined, unlisted opcode/funct encodings raise
//                        out_illegal; otherwise they decode as silent NOPs.
// -----------------------------------------------------------------------------
module dlx_decode_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic              clk,
  input logic              reset_n,
  dlx_decode_pipe_if.slave bus
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2,  ALU_AND = 4'd3,
    ALU_OR   = 4'd4,  ALU_XOR  = 4'd5,  ALU_SLL  = 4'd6,  ALU_SRL = 4'd7,
    ALU_BEQZ = 4'd8,  ALU_BNEZ = 4'd9,  ALU_SEQ  = 4'd10, ALU_SLE = 4'd11,
    ALU_SLT  = 4'd12, ALU_SNE  = 4'd13, ALU_SRA  = 4'd14, ALU_JAL = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    alu_op_e         alu_op;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            load;
    logic            store;
    logic [1:0]      pc_cmd;
    logic [1:0]      pc_val;
    logic            illegal;
  } dec_word_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_BEQZ = 6'h04, OPC_BNEZ = 6'h05,
                         OPC_ADDI  = 6'h08, OPC_SUBI = 6'h0a, OPC_ANDI = 6'h0c,
                         OPC_ORI   = 6'h0d, OPC_XORI = 6'h0e, OPC_LHI  = 6'h0f,
                         OPC_J     = 6'h12, OPC_JAL  = 6'h13, OPC_SLLI = 6'h14,
                         OPC_SRLI  = 6'h16, OPC_SRAI = 6'h17, OPC_SEQI = 6'h18,
                         OPC_SNEI  = 6'h19, OPC_SLTI = 6'h1a, OPC_SLEI = 6'h1c,
                         OPC_LW    = 6'h23, OPC_SW   = 6'h2b;

  logic [5:0]    opcode;
  logic [10:0]   funct;
  logic [15:0]   imm16;
  dec_word_t     dec;
  dec_word_t     out_q;
  logic          legal;
  logic          sext;
  logic          rs2_use;
  logic          hazard;
  logic          in_ready;
  logic          accept;
  logic          out_valid_q;
  logic          ld_v_q;
  logic [RW-1:0] ld_rd_q;

  assign opcode = bus.in_instr[31:26];
  assign funct  = bus.in_instr[10:0];
  assign imm16  = bus.in_instr[15:0];

  // ---------------------------------------------------------------------------
  // Combinational decode of the instruction presented by fetch.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    dec     = '0;
    legal   = 1'b1;
    sext    = 1'b0;
    dec.pc  = bus.in_pc;
    dec.rs1 = RW'(bus.in_instr[25:21]);
    dec.rs2 = RW'(bus.in_instr[20:16]);

    if (opcode == OPC_RTYPE) begin
      dec.rd = RW'(bus.in_instr[15:11]);
      unique case (funct)
        11'h020: dec.alu_op = ALU_ADD;
        11'h022: dec.alu_op = ALU_SUB;
        11'h024: dec.alu_op = ALU_AND;
        11'h025: dec.alu_op = ALU_OR;
        11'h026: dec.alu_op = ALU_XOR;
        11'h004: dec.alu_op = ALU_SLL;
        11'h006: dec.alu_op = ALU_SRL;
        11'h007: dec.alu_op = ALU_SRA;
        11'h028: dec.alu_op = ALU_SEQ;
        11'h029: dec.alu_op = ALU_SNE;
        11'h02a: dec.alu_op = ALU_SLT;
        11'h02c: dec.alu_op = ALU_SLE;
        default: legal = 1'b0;
      endcase
    end else begin
      dec.use_imm = 1'b1;
      dec.rd      = RW'(bus.in_instr[20:16]);
      unique case (opcode)
        OPC_ADDI: begin dec.alu_op = ALU_ADD; sext = 1'b1; end
        OPC_SUBI: begin dec.alu_op = ALU_SUB; sext = 1'b1; end
        OPC_SEQI: begin dec.alu_op = ALU_SEQ; sext = 1'b1; end
        OPC_SNEI: begin dec.alu_op = ALU_SNE; sext = 1'b1; end
        OPC_SLTI: begin dec.alu_op = ALU_SLT; sext = 1'b1; end
        OPC_SLEI: begin dec.alu_op = ALU_SLE; sext = 1'b1; end
        OPC_LW: begin
          dec.alu_op = ALU_ADD;
          sext       = 1'b1;
          dec.load   = 1'b1;
        end
        OPC_SW: begin
          dec.alu_op = ALU_ADD;
          sext       = 1'b1;
          dec.store  = 1'b1;
          dec.rd     = '0;
        end
        OPC_BEQZ, OPC_BNEZ: begin
          dec.alu_op = (opcode == OPC_BEQZ) ? ALU_BEQZ : ALU_BNEZ;
          sext       = 1'b1;
          dec.pc_cmd = 2'b10;
          dec.rd     = '0;
        end
        OPC_ANDI: dec.alu_op = ALU_AND;
        OPC_ORI:  dec.alu_op = ALU_OR;
        OPC_XORI: dec.alu_op = ALU_XOR;
        OPC_SLLI: dec.alu_op = ALU_SLL;
        OPC_SRLI: dec.alu_op = ALU_SRL;
        OPC_SRAI: dec.alu_op = ALU_SRA;
        OPC_LHI:  dec.alu_op = ALU_NOP;
        OPC_J: begin
          dec.pc_cmd = 2'b11;
          dec.pc_val = 2'b11;
          dec.rd     = '0;
        end
        OPC_JAL: begin
          dec.alu_op = ALU_JAL;
          dec.pc_cmd = 2'b11;
          dec.pc_val = 2'b11;
          dec.rd     = RW'(NREG - 1);  // link register
        end
        default: legal = 1'b0;
      endcase
      dec.imm = sext ? {{(XLEN-16){imm16[15]}}, imm16} : {{(XLEN-16){1'b0}}, imm16};
    end

    // Undecodable encodings travel on as a NOP that writes nothing.
    if (!legal) begin
      dec.alu_op  = ALU_NOP;
      dec.rd      = '0;
      dec.imm     = '0;
      dec.use_imm = 1'b0;
    end

`ifdef DLX_DECODE_TRAP_EN
    dec.illegal = !legal;
`else
    dec.illegal = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Load-use interlock: the instruction presented right after a load left for
  // execute waits one cycle if it reads the load's destination.
  // ---------------------------------------------------------------------------
  assign rs2_use = (opcode == OPC_RTYPE) || (opcode == OPC_SW) ||
                   (opcode == OPC_BEQZ)  || (opcode == OPC_BNEZ);
  assign hazard  = bus.in_valid && ld_v_q &&
                   ((dec.rs1 == ld_rd_q) || (rs2_use && (dec.rs2 == ld_rd_q)));

  // Holding reset keeps fetch stalled; flush wins over any accept.
  assign in_ready = reset_n && (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Output register toward execute.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ld_v_q      <= 1'b0;
      ld_rd_q     <= '0;
    end else begin
      // Pulses for exactly the cycle after a destination-writing load leaves.
      ld_v_q  <= !bus.flush && out_valid_q && bus.out_ready && out_q.load && (out_q.rd != '0);
      ld_rd_q <= out_q.rd;

      if (bus.flush)          out_valid_q <= 1'b0;
      else if (accept)        out_valid_q <= 1'b1;
      else if (bus.out_ready) out_valid_q <= 1'b0;

      if (accept) out_q <= dec;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_alu_op  = out_q.alu_op;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_use_imm = out_q.use_imm;
  assign bus.out_load    = out_q.load;
  assign bus.out_store   = out_q.store;
  assign bus.out_pc_cmd  = out_q.pc_cmd;
  assign bus.out_pc_val  = out_q.pc_val;
  assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_dlx_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_dlx_decode_pipe
// Self-checking bench for dlx_decode_pipe (XLEN=64, NREG=32). Directed
// scenarios compare against hand-derived constants; a randomized run compares
// every cycle against a table-driven reference model of the decoder.
// -----------------------------------------------------------------------------
module tb_dlx_decode_pipe;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

`ifdef DLX_DECODE_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            load;
    logic            store;
    logic [1:0]      pc_cmd;
    logic [1:0]      pc_val;
    logic            illegal;
  } word_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dlx_decode_pipe_if #(.XLEN(XLEN), .NREG(NREG)) bus ();
  dlx_decode_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference decode tables.
  int         r_op   [bit [10:0]];
  int         i_op   [bit [5:0]];
  bit         i_sext [bit [5:0]];
  bit [5:0]   opc_list[$];
  bit [10:0]  fn_list [$];

  // Reference model state.
  word_t         exp_w  = '0;
  bit            exp_ov = 1'b0;
  bit            m_ld_v = 1'b0;
  logic [RW-1:0] m_ld_rd = '0;

  localparam logic [31:0] I_ADD  = 32'h00221820;  // ADD r3,r1,r2
  localparam logic [31:0] I_XOR  = 32'h00223826;  // XOR r7,r1,r2
  localparam logic [31:0] I_LW   = 32'h8C250000;  // LW r5,0(r1)
  localparam logic [31:0] I_ADD6 = 32'h00A53020;  // ADD r6,r5,r5

  task automatic add_r(bit [10:0] fn, int op);
    r_op[fn] = op;
    fn_list.push_back(fn);
  endtask

  task automatic add_i(bit [5:0] opc, int op, bit se);
    i_op[opc]   = op;
    i_sext[opc] = se;
    opc_list.push_back(opc);
  endtask

  task automatic init_tables();
    add_r(11'h020, 1);  add_r(11'h022, 2);  add_r(11'h024, 3);  add_r(11'h025, 4);
    add_r(11'h026, 5);  add_r(11'h004, 6);  add_r(11'h006, 7);  add_r(11'h007, 14);
    add_r(11'h028, 10); add_r(11'h029, 13); add_r(11'h02a, 12); add_r(11'h02c, 11);
    add_i(6'h08, 1, 1);  add_i(6'h0a, 2, 1);  add_i(6'h18, 10, 1); add_i(6'h19, 13, 1);
    add_i(6'h1a, 12, 1); add_i(6'h1c, 11, 1); add_i(6'h23, 1, 1);  add_i(6'h2b, 1, 1);
    add_i(6'h04, 8, 1);  add_i(6'h05, 9, 1);  add_i(6'h0c, 3, 0);  add_i(6'h0d, 4, 0);
    add_i(6'h0e, 5, 0);  add_i(6'h14, 6, 0);  add_i(6'h16, 7, 0);  add_i(6'h17, 14, 0);
    add_i(6'h0f, 0, 0);  add_i(6'h12, 0, 0);  add_i(6'h13, 15, 0);
  endtask

  function automatic word_t ref_decode(logic [31:0] instr, logic [XLEN-1:0] pc);
    word_t    w;
    bit [5:0] opc;
    bit [10:0] fn;
    longint   v;
    w   = '0;
    opc = instr[31:26];
    fn  = instr[10:0];
    w.pc  = pc;
    w.rs1 = RW'(instr[25:21]);
    w.rs2 = RW'(instr[20:16]);
    if (opc == 6'h00 && r_op.exists(fn)) begin
      w.alu_op = 4'(r_op[fn]);
      w.rd     = RW'(instr[15:11]);
    end else if (opc != 6'h00 && i_op.exists(opc)) begin
      w.alu_op  = 4'(i_op[opc]);
      w.use_imm = 1'b1;
      w.rd      = RW'(instr[20:16]);
      v = longint'(instr[15:0]);
      if (i_sext[opc] && v >= 32768) v = v - 65536;
      w.imm = XLEN'(v);
      if (opc == 6'h23) w.load = 1'b1;
      if (opc == 6'h2b) begin w.store = 1'b1; w.rd = '0; end
      if (opc == 6'h04 || opc == 6'h05) begin w.pc_cmd = 2'b10; w.rd = '0; end
      if (opc == 6'h12 || opc == 6'h13) begin
        w.pc_cmd = 2'b11;
        w.pc_val = 2'b11;
        w.rd     = (opc == 6'h13) ? RW'(NREG - 1) : '0;
      end
    end else begin
      w.illegal = TRAP;
    end
    return w;
  endfunction

  function automatic word_t dut_word();
    word_t w;
    w.pc      = bus.out_pc;
    w.alu_op  = bus.out_alu_op;
    w.rs1     = bus.out_rs1;
    w.rs2     = bus.out_rs2;
    w.rd      = bus.out_rd;
    w.imm     = bus.out_imm;
    w.use_imm = bus.out_use_imm;
    w.load    = bus.out_load;
    w.store   = bus.out_store;
    w.pc_cmd  = bus.out_pc_cmd;
    w.pc_val  = bus.out_pc_val;
    w.illegal = bus.out_illegal;
    return w;
  endfunction

  // Expected in_ready for the inputs currently driven.
  function automatic bit model_ready();
    logic [31:0] ins;
    bit [5:0]    opc;
    bit          reads_rs2;
    bit          haz;
    ins = bus.in_instr;
    opc = ins[31:26];
    reads_rs2 = (opc == 6'h00) || (opc == 6'h2b) || (opc == 6'h04) || (opc == 6'h05);
    haz = bus.in_valid && m_ld_v &&
          ((RW'(ins[25:21]) == m_ld_rd) || (reads_rs2 && (RW'(ins[20:16]) == m_ld_rd)));
    return reset_n && (!exp_ov || bus.out_ready) && !haz && !bus.flush;
  endfunction

  // Advance one clock; the model follows the same inputs. Returns at edge+1.
  task automatic cycle();
    bit            acc;
    bit            n_ov;
    bit            n_ld_v;
    logic [RW-1:0] n_ld_rd;
    word_t         n_w;
    acc  = bus.in_valid && model_ready();
    n_w  = acc ? ref_decode(bus.in_instr, bus.in_pc) : exp_w;
    n_ov = exp_ov;
    n_ld_v  = 1'b0;
    n_ld_rd = exp_w.rd;
    if (!reset_n) begin
      n_ov = 1'b0;
      n_w  = '0;
    end else begin
      n_ld_v = !bus.flush && exp_ov && bus.out_ready && exp_w.load && (exp_w.rd != '0);
      if (bus.flush)          n_ov = 1'b0;
      else if (acc)           n_ov = 1'b1;
      else if (bus.out_ready) n_ov = 1'b0;
    end
    @(posedge clk);
    exp_ov  = n_ov;
    exp_w   = n_w;
    m_ld_v  = n_ld_v;
    m_ld_rd = n_ld_rd;
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] instr, logic [XLEN-1:0] pc, bit rdy, bit fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, I_ADD, 64'h10, 1'b1, 1'b0);
    cycle();
    cycle();
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (dut_word() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_word()); else n_pass++;
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); else n_pass++;
    cycle();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_add();
    drive(1'b1, I_ADD, 64'h100, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL add_ready: got %b want 1", bus.in_ready); else n_pass++;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_alu_op !== 4'd1) $display("FAIL add_op: got %0d want 1", bus.out_alu_op); else n_pass++;
    n_checks++; if ({bus.out_rs1, bus.out_rs2, bus.out_rd} !== {5'd1, 5'd2, 5'd3})
      $display("FAIL add_regs: got %0d/%0d/%0d want 1/2/3", bus.out_rs1, bus.out_rs2, bus.out_rd); else n_pass++;
    n_checks++; if (bus.out_use_imm !== 1'b0) $display("FAIL add_use_imm: got %b want 0", bus.out_use_imm); else n_pass++;
    n_checks++; if (bus.out_pc !== 64'h100) $display("FAIL add_pc: got %h want 100", bus.out_pc); else n_pass++;
    cycle();
  endtask

  task automatic test_imm();
    drive(1'b1, 32'h2004FFFF, 64'h200, 1'b1, 1'b0);   // ADDI r4,r0,-1
    cycle();
    drive(1'b1, 32'h3004FFFF, 64'h204, 1'b1, 1'b0);   // ANDI r4,r0,0xFFFF
    #1;
    n_checks++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL addi_imm: got %h want ffffffffffffffff", bus.out_imm); else n_pass++;
    n_checks++; if ({bus.out_alu_op, bus.out_rd, bus.out_use_imm} !== {4'd1, 5'd4, 1'b1})
      $display("FAIL addi_fields: got op %0d rd %0d ui %b want 1 4 1", bus.out_alu_op, bus.out_rd, bus.out_use_imm); else n_pass++;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_imm !== 64'h0000_0000_0000_FFFF) $display("FAIL andi_imm: got %h want ffff", bus.out_imm); else n_pass++;
    n_checks++; if ({bus.out_alu_op, bus.out_rd} !== {4'd3, 5'd4})
      $display("FAIL andi_fields: got op %0d rd %0d want 3 4", bus.out_alu_op, bus.out_rd); else n_pass++;
    cycle();
  endtask

  task automatic test_load_use();
    drive(1'b1, I_LW, 64'h300, 1'b1, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if ({bus.out_valid, bus.out_load, bus.out_rd} !== {1'b1, 1'b1, 5'd5})
      $display("FAIL lw_out: got v %b ld %b rd %0d want 1 1 5", bus.out_valid, bus.out_load, bus.out_rd); else n_pass++;
    cycle();                                       // LW leaves here
    drive(1'b1, I_ADD6, 64'h304, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL hazard_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL hazard_bubble: got %b want 0", bus.out_valid); else n_pass++;
    cycle();
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL hazard_release: got %b want 1", bus.in_ready); else n_pass++;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if ({bus.out_valid, bus.out_alu_op, bus.out_rd} !== {1'b1, 4'd1, 5'd6})
      $display("FAIL hazard_add_out: got v %b op %0d rd %0d want 1 1 6", bus.out_valid, bus.out_alu_op, bus.out_rd); else n_pass++;
    cycle();
  endtask

  task automatic test_backpressure();
    word_t held;
    held = ref_decode(I_ADD, 64'h400);
    drive(1'b1, I_ADD, 64'h400, 1'b1, 1'b0);
    cycle();
    drive(1'b1, I_XOR, 64'h404, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.out_valid); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.in_ready); else n_pass++;
      n_checks++; if (dut_word() !== held) $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_word(), held); else n_pass++;
      cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); else n_pass++;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (dut_word() !== ref_decode(I_XOR, 64'h404))
      $display("FAIL stall_next_word: got %h want %h", dut_word(), ref_decode(I_XOR, 64'h404)); else n_pass++;
    cycle();
  endtask

  task automatic test_flush();
    drive(1'b1, I_ADD, 64'h500, 1'b1, 1'b0);
    cycle();
    drive(1'b1, I_XOR, 64'h504, 1'b0, 1'b1);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", bus.in_ready); else n_pass++;
    cycle();
    drive(1'b0, I_XOR, 64'h504, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.out_valid); else n_pass++;
    cycle();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_not_accepted: got %b want 0", bus.out_valid); else n_pass++;
    // A load leaving under flush must not arm the interlock.
    drive(1'b1, I_LW, 64'h508, 1'b1, 1'b0);
    cycle();
    drive(1'b0, I_LW, 64'h508, 1'b1, 1'b1);
    cycle();
    drive(1'b1, I_ADD6, 64'h50c, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_clears_interlock: got %b want 1", bus.in_ready); else n_pass++;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'hFC221820;   // opcode 0x3F
    bad[1] = 32'h00221821;   // R-type, unlisted funct
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bad[i], 64'h600, 1'b1, 1'b0);
      cycle();
      bus.in_valid = 1'b0;
      #1;
      n_checks++; if ({bus.out_valid, bus.out_illegal} !== {1'b1, TRAP})
        $display("FAIL illegal_flag[%0d]: got v %b ill %b want 1 %b", i, bus.out_valid, bus.out_illegal, TRAP); else n_pass++;
      n_checks++; if ({bus.out_alu_op, bus.out_rd, bus.out_load, bus.out_store, bus.out_pc_cmd} !== '0)
        $display("FAIL illegal_nop[%0d]: got op %0d rd %0d ld %b st %b pcc %b want 0", i,
                 bus.out_alu_op, bus.out_rd, bus.out_load, bus.out_store, bus.out_pc_cmd); else n_pass++;
      cycle();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    bit [5:0]    opc;
    bit [10:0]   fn;
    int          k;
    k = $urandom_range(0, 19);
    if (k == 0) return $urandom();
    opc = (k < 6) ? 6'h00 : (k < 9) ? 6'h23 : opc_list[$urandom_range(0, opc_list.size() - 1)];
    fn  = (k == 1) ? 11'($urandom()) : fn_list[$urandom_range(0, fn_list.size() - 1)];
    ins = {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom())};
    if (opc == 6'h00) ins[15:0] = {5'($urandom_range(0, 3)), fn};
    return ins;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), XLEN'({$urandom(), $urandom()}),
            $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
      #1;
      n_checks++; if (bus.in_ready !== model_ready())
        $display("FAIL rand_in_ready @%0d: got %b want %b", i, bus.in_ready, model_ready()); else n_pass++;
      n_checks++; if (bus.out_valid !== exp_ov)
        $display("FAIL rand_out_valid @%0d: got %b want %b", i, bus.out_valid, exp_ov); else n_pass++;
      if (exp_ov) begin
        n_checks++; if (dut_word() !== exp_w)
          $display("FAIL rand_word @%0d: got %h want %h", i, dut_word(), exp_w); else n_pass++;
      end
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    cycle();
  endtask

  initial begin
    init_tables();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_imm();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
